// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: round-robin arbitration of the ALU and load paths onto the
// single register-file write port, plus the per-register busy scoreboard.
module regfile_wb_sched #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8,
   parameter int IW     = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alu_valid,
   input  logic [IW-1:0]     alu_dr,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   input  logic              ld_valid,
   input  logic [IW-1:0]     ld_dr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   input  logic              rsv_valid,
   input  logic [IW-1:0]     rsv_dr,
   output logic              regWE,
   output logic [IW-1:0]     DR,
   output logic [DATA_W-1:0] b,
   output logic [NREG-1:0]   busy,
   output logic              wb_err
);

   // Handshake: a requester transfers on a cycle where its valid and ready are both
   // high. Ready is a pure function of both valids and prio (never of the requester's
   // own ready), at most one ready is high, and a dropped valid withdraws the request.
   logic              prio;
   logic              grant_alu;
   logic              grant_ld;
   logic              grant;
   logic              contested;
   logic [IW-1:0]     grant_dr;
   logic [DATA_W-1:0] grant_data;
   logic [NREG-1:0]   busy_next;

   always_comb begin
      contested  = alu_valid && ld_valid;
      grant_alu  = alu_valid && (!ld_valid || !prio);
      grant_ld   = ld_valid && (!alu_valid || prio);
      grant      = grant_alu || grant_ld;
      grant_dr   = grant_alu ? alu_dr : ld_dr;
      grant_data = grant_alu ? alu_data : ld_data;
      alu_ready  = grant_alu;
      ld_ready   = grant_ld;
   end

   // Set is applied after clear so a fresh reservation outlives a committing write.
   always_comb begin
      busy_next = busy;
      if (regWE) begin
         busy_next[DR] = 1'b0;
      end
      if (rsv_valid) begin
         busy_next[rsv_dr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regWE  <= 1'b0;
         DR     <= '0;
         b      <= '0;
         busy   <= '0;
         wb_err <= 1'b0;
         prio   <= 1'b0;
      end else begin
         regWE <= grant;
         if (grant) begin
            DR <= grant_dr;
            b  <= grant_data;
         end
         if (contested) begin
            prio <= ~prio;
         end
         if (grant && !busy[grant_dr]) begin
            wb_err <= 1'b1;
         end
         busy <= busy_next;
      end
   end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed scenarios plus a randomized run against
// a cycle-level behavioural model of the scheduler.
module tb_regfile_wb_sched;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        alu_valid = 1'b0;
   logic [2:0]  alu_dr = '0;
   logic [15:0] alu_data = '0;
   logic        alu_ready;
   logic        ld_valid = 1'b0;
   logic [2:0]  ld_dr = '0;
   logic [15:0] ld_data = '0;
   logic        ld_ready;
   logic        rsv_valid = 1'b0;
   logic [2:0]  rsv_dr = '0;
   logic        regWE;
   logic [2:0]  DR;
   logic [15:0] b;
   logic [7:0]  busy;
   logic        wb_err;

   int total = 0;
   int bad = 0;

   // behavioural model state
   bit          m_busy [8];
   int          m_next_turn;
   bit          m_err;
   bit          m_we;
   logic [2:0]  m_dr;
   logic [15:0] m_b;

   regfile_wb_sched dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_dr(alu_dr), .alu_data(alu_data), .alu_ready(alu_ready),
      .ld_valid(ld_valid), .ld_dr(ld_dr), .ld_data(ld_data), .ld_ready(ld_ready),
      .rsv_valid(rsv_valid), .rsv_dr(rsv_dr),
      .regWE(regWE), .DR(DR), .b(b), .busy(busy), .wb_err(wb_err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] model_busy_vec();
      logic [7:0] v;
      for (int i = 0; i < 8; i++) v[i] = m_busy[i];
      return v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
      m_next_turn = 0;
      m_err = 1'b0;
      m_we = 1'b0;
      m_dr = '0;
      m_b = '0;
   endtask

   // Advances the model across one rising edge using the currently driven inputs.
   task automatic model_edge(output bit took_alu, output bit took_ld);
      bit nb [8];
      int winner;
      winner = -1;
      if (alu_valid && ld_valid) begin
         winner = m_next_turn;
         m_next_turn = 1 - m_next_turn;
      end else if (alu_valid) winner = 0;
      else if (ld_valid) winner = 1;
      took_alu = (winner == 0);
      took_ld = (winner == 1);
      nb = m_busy;
      if (m_we) nb[m_dr] = 1'b0;
      if (rsv_valid) nb[rsv_dr] = 1'b1;
      if (winner >= 0) begin
         if (!m_busy[took_alu ? alu_dr : ld_dr]) m_err = 1'b1;
         m_dr = took_alu ? alu_dr : ld_dr;
         m_b = took_alu ? alu_data : ld_data;
         m_we = 1'b1;
      end else begin
         m_we = 1'b0;
      end
      m_busy = nb;
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0;
      ld_valid = 1'b0;
      rsv_valid = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_clear();
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      alu_valid = 1'b1; alu_dr = 3'd4; alu_data = 16'hBEEF;
      ld_valid = 1'b1; ld_dr = 3'd2; ld_data = 16'h0F0F;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({regWE, busy, wb_err} !== {1'b0, 8'h00, 1'b0}) begin
         bad++;
         $display("FAIL reset_state: regWE=%b busy=%h wb_err=%b want 0/00/0", regWE, busy, wb_err);
      end
      total++;
      if ({alu_ready, ld_ready} !== 2'b10) begin
         bad++;
         $display("FAIL reset_ready: alu_ready=%b ld_ready=%b want 1/0", alu_ready, ld_ready);
      end
      reset = 1'b1;
      next_cycle();
      idle_inputs();
      @(negedge clk);
      total++;
      if ({regWE, DR, b} !== {1'b1, 3'd4, 16'hBEEF}) begin
         bad++;
         $display("FAIL reset_first_write: regWE=%b DR=%0d b=%h want 1/4/beef", regWE, DR, b);
      end
   endtask

   task automatic test_single_write();
      do_reset();
      rsv_valid = 1'b1; rsv_dr = 3'd3;
      next_cycle();
      rsv_valid = 1'b0;
      next_cycle();
      alu_valid = 1'b1; alu_dr = 3'd3; alu_data = 16'h1234;
      @(negedge clk);
      total++;
      if ({alu_ready, ld_ready} !== 2'b10) begin
         bad++;
         $display("FAIL single_ready: alu_ready=%b ld_ready=%b want 1/0", alu_ready, ld_ready);
      end
      next_cycle();
      alu_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({regWE, DR, b, busy} !== {1'b1, 3'd3, 16'h1234, 8'h08}) begin
         bad++;
         $display("FAIL single_commit: regWE=%b DR=%0d b=%h busy=%h want 1/3/1234/08", regWE, DR, b, busy);
      end
      next_cycle();
      @(negedge clk);
      total++;
      if ({regWE, busy, wb_err} !== {1'b0, 8'h00, 1'b0}) begin
         bad++;
         $display("FAIL single_clear: regWE=%b busy=%h wb_err=%b want 0/00/0", regWE, busy, wb_err);
      end
   endtask

   task automatic test_contention();
      do_reset();
      rsv_valid = 1'b1; rsv_dr = 3'd1;
      next_cycle();
      rsv_dr = 3'd2;
      next_cycle();
      rsv_valid = 1'b0;
      alu_valid = 1'b1; alu_dr = 3'd1; alu_data = 16'hAAAA;
      ld_valid = 1'b1; ld_dr = 3'd2; ld_data = 16'h5555;
      @(negedge clk);
      total++;
      if ({alu_ready, ld_ready} !== 2'b10) begin
         bad++;
         $display("FAIL contest_first: alu_ready=%b ld_ready=%b want 1/0", alu_ready, ld_ready);
      end
      next_cycle();
      @(negedge clk);
      total++;
      if ({alu_ready, ld_ready} !== 2'b01) begin
         bad++;
         $display("FAIL contest_second: alu_ready=%b ld_ready=%b want 0/1", alu_ready, ld_ready);
      end
      total++;
      if ({regWE, DR, b, busy} !== {1'b1, 3'd1, 16'hAAAA, 8'h06}) begin
         bad++;
         $display("FAIL contest_alu_commit: regWE=%b DR=%0d b=%h busy=%h want 1/1/aaaa/06", regWE, DR, b, busy);
      end
      next_cycle();
      @(negedge clk);
      total++;
      if ({alu_ready, ld_ready} !== 2'b10) begin
         bad++;
         $display("FAIL contest_third: alu_ready=%b ld_ready=%b want 1/0", alu_ready, ld_ready);
      end
      total++;
      if ({regWE, DR, b, busy} !== {1'b1, 3'd2, 16'h5555, 8'h04}) begin
         bad++;
         $display("FAIL contest_ld_commit: regWE=%b DR=%0d b=%h busy=%h want 1/2/5555/04", regWE, DR, b, busy);
      end
      idle_inputs();
      next_cycle();
      @(negedge clk);
      total++;
      if ({regWE, busy, wb_err} !== {1'b0, 8'h00, 1'b0}) begin
         bad++;
         $display("FAIL contest_drain: regWE=%b busy=%h wb_err=%b want 0/00/0", regWE, busy, wb_err);
      end
   endtask

   task automatic test_collision();
      do_reset();
      rsv_valid = 1'b1; rsv_dr = 3'd5;
      next_cycle();
      rsv_valid = 1'b0;
      alu_valid = 1'b1; alu_dr = 3'd5; alu_data = 16'hC0DE;
      next_cycle();
      alu_valid = 1'b0;
      rsv_valid = 1'b1; rsv_dr = 3'd5;
      @(negedge clk);
      total++;
      if ({regWE, DR, busy} !== {1'b1, 3'd5, 8'h20}) begin
         bad++;
         $display("FAIL collide_commit: regWE=%b DR=%0d busy=%h want 1/5/20", regWE, DR, busy);
      end
      next_cycle();
      rsv_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({regWE, busy} !== {1'b0, 8'h20}) begin
         bad++;
         $display("FAIL collide_set_wins: regWE=%b busy=%h want 0/20", regWE, busy);
      end
   endtask

   task automatic test_error();
      do_reset();
      ld_valid = 1'b1; ld_dr = 3'd6; ld_data = 16'h6666;
      @(negedge clk);
      total++;
      if ({ld_ready, wb_err} !== 2'b10) begin
         bad++;
         $display("FAIL err_before: ld_ready=%b wb_err=%b want 1/0", ld_ready, wb_err);
      end
      next_cycle();
      ld_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({regWE, DR, b, wb_err} !== {1'b1, 3'd6, 16'h6666, 1'b1}) begin
         bad++;
         $display("FAIL err_write: regWE=%b DR=%0d b=%h wb_err=%b want 1/6/6666/1", regWE, DR, b, wb_err);
      end
      repeat (3) next_cycle();
      @(negedge clk);
      total++;
      if (wb_err !== 1'b1) begin
         bad++;
         $display("FAIL err_sticky: wb_err=%b want 1", wb_err);
      end
      do_reset();
      @(negedge clk);
      total++;
      if (wb_err !== 1'b0) begin
         bad++;
         $display("FAIL err_reset: wb_err=%b want 0", wb_err);
      end
   endtask

   task automatic test_reset_mid_write();
      do_reset();
      rsv_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rsv_dr = 3'(i);
         if (i == 7) begin
            alu_valid = 1'b1; alu_dr = 3'd0; alu_data = 16'h0A0A;
         end
         next_cycle();
      end
      idle_inputs();
      @(negedge clk);
      total++;
      if ({regWE, busy, wb_err} !== {1'b1, 8'hFF, 1'b0}) begin
         bad++;
         $display("FAIL midrst_before: regWE=%b busy=%h wb_err=%b want 1/ff/0", regWE, busy, wb_err);
      end
      #1;
      reset = 1'b0;
      #1;
      total++;
      if ({regWE, busy} !== {1'b0, 8'h00}) begin
         bad++;
         $display("FAIL midrst_async: regWE=%b busy=%h want 0/00", regWE, busy);
      end
      next_cycle();
      reset = 1'b1;
   endtask

   task automatic test_random();
      bit took_a, took_l, exp_ar, exp_lr;
      do_reset();
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         exp_ar = alu_valid && (!ld_valid || m_next_turn == 0);
         exp_lr = ld_valid && (!alu_valid || m_next_turn == 1);
         total++;
         if ({alu_ready, ld_ready} !== {exp_ar, exp_lr}) begin
            bad++;
            $display("FAIL rand_ready c=%0d: got %b%b want %b%b", c, alu_ready, ld_ready, exp_ar, exp_lr);
         end
         total++;
         if (regWE !== m_we || (m_we && {DR, b} !== {m_dr, m_b})) begin
            bad++;
            $display("FAIL rand_port c=%0d: regWE=%b DR=%0d b=%h want %b/%0d/%h", c, regWE, DR, b, m_we, m_dr, m_b);
         end
         total++;
         if ({busy, wb_err} !== {model_busy_vec(), m_err}) begin
            bad++;
            $display("FAIL rand_sb c=%0d: busy=%h wb_err=%b want %h/%b", c, busy, wb_err, model_busy_vec(), m_err);
         end
         model_edge(took_a, took_l);
         next_cycle();
         if (took_a) alu_valid = 1'b0;
         if (took_l) ld_valid = 1'b0;
         if (!alu_valid && $urandom_range(0, 2) != 0) begin
            alu_valid = 1'b1; alu_dr = 3'($urandom_range(0, 7)); alu_data = 16'($urandom);
         end else if (alu_valid && $urandom_range(0, 9) == 0) begin
            alu_valid = 1'b0;
         end
         if (!ld_valid && $urandom_range(0, 2) != 0) begin
            ld_valid = 1'b1; ld_dr = 3'($urandom_range(0, 7)); ld_data = 16'($urandom);
         end else if (ld_valid && $urandom_range(0, 9) == 0) begin
            ld_valid = 1'b0;
         end
         rsv_valid = ($urandom_range(0, 3) != 0);
         rsv_dr = 3'($urandom_range(0, 7));
      end
      idle_inputs();
   endtask

   initial begin
      model_clear();
      test_reset();
      test_single_write();
      test_contention();
      test_collision();
      test_error();
      test_reset_mid_write();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
